// File: rtl/mdr_seq.sv
// rtl/mdr_seq.sv - SAP-II MDR/RAM access sequencer
// Moore FSM; every output is a flop fed from a decode of the next state, so strobes are glitch-free.
module mdr_seq #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic CLK,
  input  logic CLR,
  input  logic rd_req,
  input  logic wr_req,
  output logic busy,
  output logic done,
  output logic op,
  output logic nLw,
  output logic nLr,
  output logic Ew,
  output logic Er,
  output logic nWE,
  output logic nOE
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_LOAD   = 3'd1,
    W_DRIVE  = 3'd2,
    W_END    = 3'd3,
    R_ACCESS = 3'd4,
    R_LATCH  = 3'd5,
    R_DRIVE  = 3'd6
  } state_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic nlw;
    logic nlr;
    logic ew;
    logic er;
    logic nwe;
    logic noe;
  } outs_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam outs_t OUTS_IDLE = '{busy: 1'b0, done: 1'b0, nlw: 1'b1, nlr: 1'b1,
                                  ew: 1'b0, er: 1'b0, nwe: 1'b1, noe: 1'b1};

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  // op doubles as the round-robin last-grant flag: both always hold the most recent grant.
  logic       op_q, op_nx;
  outs_t      outs_q, outs_d;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      op_q   <= 1'b0;
      outs_q <= OUTS_IDLE;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      op_q   <= op_nx;
      outs_q <= outs_d;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    case (state)
      IDLE: begin
        // On a tie, write wins only if the previous grant was a read.
        if (wr_req && (!rd_req || !op_q)) begin
          state_nx = W_LOAD;
          op_nx    = 1'b1;
        end else if (rd_req) begin
          state_nx = R_ACCESS;
          op_nx    = 1'b0;
          cnt_nx   = CNT_LOAD;
        end
      end
      W_LOAD: begin
        state_nx = W_DRIVE;
        cnt_nx   = CNT_LOAD;
      end
      W_DRIVE: begin
        if (cnt == 4'd0) state_nx = W_END;
        else             cnt_nx   = cnt - 4'd1;
      end
      W_END:   state_nx = IDLE;
      R_ACCESS: begin
        if (cnt == 4'd0) state_nx = R_LATCH;
        else             cnt_nx   = cnt - 4'd1;
      end
      R_LATCH: state_nx = R_DRIVE;
      R_DRIVE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    outs_d = OUTS_IDLE;
    case (state_nx)
      W_LOAD: begin
        outs_d.busy = 1'b1;
        outs_d.nlw  = 1'b0;
      end
      W_DRIVE: begin
        outs_d.busy = 1'b1;
        outs_d.er   = 1'b1;
        outs_d.nwe  = 1'b0;
      end
      W_END: begin
        // Keep driving the RAM bus one cycle past the strobe for data hold.
        outs_d.busy = 1'b1;
        outs_d.er   = 1'b1;
        outs_d.done = 1'b1;
      end
      R_ACCESS: begin
        outs_d.busy = 1'b1;
        outs_d.noe  = 1'b0;
      end
      R_LATCH: begin
        outs_d.busy = 1'b1;
        outs_d.noe  = 1'b0;
        outs_d.nlr  = 1'b0;
      end
      R_DRIVE: begin
        outs_d.busy = 1'b1;
        outs_d.ew   = 1'b1;
        outs_d.done = 1'b1;
      end
      default: outs_d = OUTS_IDLE;
    endcase
  end

  assign busy = outs_q.busy;
  assign done = outs_q.done;
  assign op   = op_q;
  assign nLw  = outs_q.nlw;
  assign nLr  = outs_q.nlr;
  assign Ew   = outs_q.ew;
  assign Er   = outs_q.er;
  assign nWE  = outs_q.nwe;
  assign nOE  = outs_q.noe;

endmodule

// File: tb/tb_mdr_seq.sv
// tb/tb_mdr_seq.sv - directed and random-stream bench for mdr_seq
// Instance 0 runs WAIT_CYCLES=2 with an MDR/RAM model; instances 1 and 2 run 1 and 15.
module tb_mdr_seq;

  // Output vector order: busy, done, op, nLw, nLr, Ew, Er, nWE, nOE
  localparam logic [8:0] S_IDLE0 = 9'b000110011;
  localparam logic [8:0] S_IDLE1 = 9'b001110011;
  localparam logic [8:0] S_WLOAD = 9'b101010011;
  localparam logic [8:0] S_WDRV  = 9'b101110101;
  localparam logic [8:0] S_WEND  = 9'b111110111;
  localparam logic [8:0] S_RACC  = 9'b100110010;
  localparam logic [8:0] S_RLAT  = 9'b100100010;
  localparam logic [8:0] S_RDRV  = 9'b110111011;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       CLR;
  logic [2:0] rd_v, wr_v;
  logic [2:0] busy_v, done_v, op_v, nlw_v, nlr_v, ew_v, er_v, nwe_v, noe_v;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int WC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
      mdr_seq #(.WAIT_CYCLES(WC)) u_dut (
        .CLK(CLK), .CLR(CLR), .rd_req(rd_v[g]), .wr_req(wr_v[g]),
        .busy(busy_v[g]), .done(done_v[g]), .op(op_v[g]),
        .nLw(nlw_v[g]), .nLr(nlr_v[g]), .Ew(ew_v[g]), .Er(er_v[g]),
        .nWE(nwe_v[g]), .nOE(noe_v[g])
      );
    end
  endgenerate

  // MDR and RAM model attached to instance 0
  logic [7:0] mdr, wbus_drv, ld_val;
  logic [3:0] mar;
  logic       ld_ram;
  logic [7:0] ram [16];
  logic [7:0] wbus_obs;
  assign wbus_obs = ew_v[0] ? mdr : 8'h00;

  always @(posedge CLK) begin
    if (!nlw_v[0]) mdr <= wbus_drv;
    if (!nlr_v[0]) mdr <= ram[mar];
    if (ld_ram) ram[mar] <= ld_val;
    else if (!nwe_v[0] && er_v[0]) ram[mar] <= mdr;
  end

  // Invariant and busy-length monitor
  int inv_e [3];
  int len_e [3];
  int ntx   [3];
  int blen  [3];
  int done_cnt;
  logic len_en;

  function automatic int wc(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  initial begin
    for (int i = 0; i < 3; i++) begin
      inv_e[i] = 0; len_e[i] = 0; ntx[i] = 0; blen[i] = 0;
    end
    done_cnt = 0;
  end

  always @(negedge CLK) begin
    done_cnt <= done_cnt + int'(done_v[0]);
    for (int i = 0; i < 3; i++) begin
      if ((er_v[i] && !noe_v[i]) || (!nlw_v[i] && !nlr_v[i]) ||
          (ew_v[i] && !(done_v[i] && !op_v[i] && busy_v[i])) ||
          (!nwe_v[i] && !er_v[i]))
        inv_e[i] <= inv_e[i] + 1;
      if (!len_en) blen[i] <= 0;
      else if (busy_v[i]) blen[i] <= blen[i] + 1;
      else if (blen[i] != 0) begin
        if (blen[i] != wc(i) + 2) len_e[i] <= len_e[i] + 1;
        ntx[i]  <= ntx[i] + 1;
        blen[i] <= 0;
      end
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [8:0] outs0();
    return {busy_v[0], done_v[0], op_v[0], nlw_v[0], nlr_v[0],
            ew_v[0], er_v[0], nwe_v[0], noe_v[0]};
  endfunction

  int d0;

  initial begin
    CLR = 1'b1; rd_v = 3'b000; wr_v = 3'b000;
    mar = 4'd0; wbus_drv = 8'h00; ld_val = 8'h00; ld_ram = 1'b0; len_en = 1'b0;
    #2 chk("reset_outs", outs0(), S_IDLE0);
    tick(2);
    CLR = 1'b0;
    chk("idle_after_reset", outs0(), S_IDLE0);

    // Write 8'h25 to address 3
    mar = 4'd3; wbus_drv = 8'h25; wr_v[0] = 1'b1;
    tick(1); chk("w_load", outs0(), S_WLOAD);
    tick(1); chk("w_drive1", outs0(), S_WDRV); chk("mdr_from_wbus", mdr, 8'h25);
    tick(1); chk("w_drive2", outs0(), S_WDRV);
    tick(1); chk("w_end", outs0(), S_WEND);
    wr_v[0] = 1'b0;
    tick(1); chk("w_idle", outs0(), S_IDLE1); chk("ram_written", ram[3], 8'h25);

    // Read 8'h37 from address 5
    mar = 4'd5; ld_val = 8'h37; ld_ram = 1'b1;
    tick(1); ld_ram = 1'b0;
    rd_v[0] = 1'b1;
    tick(1); chk("r_access1", outs0(), S_RACC);
    tick(1); chk("r_access2", outs0(), S_RACC);
    tick(1); chk("r_latch", outs0(), S_RLAT);
    tick(1); chk("r_drive", outs0(), S_RDRV); chk("read_wbus", wbus_obs, 8'h37);
    rd_v[0] = 1'b0;
    tick(1); chk("r_idle", outs0(), S_IDLE0);

    // Round-robin with both requests held after reset
    CLR = 1'b1; tick(1); CLR = 1'b0;
    rd_v[0] = 1'b1; wr_v[0] = 1'b1;
    tick(1); chk("arb_first_write", outs0(), S_WLOAD);
    tick(4); chk("arb_gap1", outs0(), S_IDLE1);
    tick(1); chk("arb_then_read", outs0(), S_RACC);
    tick(4); chk("arb_gap2", outs0(), S_IDLE0);
    tick(1); chk("arb_write2", outs0(), S_WLOAD);
    tick(4); chk("arb_gap3", outs0(), S_IDLE1);
    tick(1); chk("arb_read2", outs0(), S_RACC);
    rd_v[0] = 1'b0; wr_v[0] = 1'b0;
    tick(4); chk("arb_end_idle", outs0(), S_IDLE0);

    // Asynchronous reset during W_DRIVE
    wr_v[0] = 1'b1;
    tick(1); chk("rst_w_load", outs0(), S_WLOAD);
    tick(1); chk("rst_w_drive", outs0(), S_WDRV);
    wr_v[0] = 1'b0;
    d0 = done_cnt;
    #3 CLR = 1'b1;
    #1 chk("rst_async_outs", outs0(), S_IDLE0);
    tick(1); CLR = 1'b0;
    tick(6);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_idle", outs0(), S_IDLE0);

    // Write request raised during a read is held off until after an IDLE cycle
    rd_v[0] = 1'b1;
    tick(1); chk("late_r_access", outs0(), S_RACC);
    wr_v[0] = 1'b1;
    tick(1); chk("late_ignored", outs0(), S_RACC);
    tick(1); chk("late_r_latch", outs0(), S_RLAT);
    tick(1); chk("late_r_drive", outs0(), S_RDRV);
    rd_v[0] = 1'b0;
    tick(1); chk("late_gap", outs0(), S_IDLE0);
    tick(1); chk("late_w_load", outs0(), S_WLOAD);
    tick(3); chk("late_w_end", outs0(), S_WEND);
    wr_v[0] = 1'b0;
    tick(1); chk("late_idle", outs0(), S_IDLE1);

    // Random request stream on all three instances
    len_en = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      rd_v = 3'($urandom_range(0, 7));
      wr_v = 3'($urandom_range(0, 7));
      tick(1);
    end
    rd_v = 3'b000; wr_v = 3'b000;
    tick(20);
    len_en = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("invariants_w%0d", wc(i)), inv_e[i], 0);
      chk($sformatf("busy_len_w%0d", wc(i)), len_e[i], 0);
      chk($sformatf("txn_seen_w%0d", wc(i)), 32'(ntx[i] >= 20), 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
